lifo_arbiter: RTL and testbench

- Shares one LIFO stack between two requesters (r0, r1) with round-robin arbitration.
- Serialises each requester's push or pop into single-cycle LIFO write/read strobes.
- Returns a completion ack, an error flag and the popped data to the requester that was served.
- Sits between client logic and the stack instance. Keeps an occupancy count as status.

---
 rtl/lifo_arbiter.sv | 112 +++++++++++
 tb/tb_lifo_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_arbiter.sv
// Round-robin arbiter sharing one LIFO between two requesters.
// One operation in flight: IDLE grants, ISSUE strobes the stack, RESP acks.
module lifo_arbiter #(
   parameter int DATA_W    = 10,
   parameter int LIFO_SIZE = 6
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           r0_req,
   input  logic                           r0_op,
   input  logic [DATA_W-1:0]              r0_wdata,
   output logic                           r0_ack,
   output logic                           r0_err,
   output logic [DATA_W-1:0]              r0_rdata,
   input  logic                           r1_req,
   input  logic                           r1_op,
   input  logic [DATA_W-1:0]              r1_wdata,
   output logic                           r1_ack,
   output logic                           r1_err,
   output logic [DATA_W-1:0]              r1_rdata,
   output logic                           lifo_write,
   output logic                           lifo_read,
   output logic [DATA_W-1:0]              lifo_datain,
   input  logic [DATA_W-1:0]              lifo_dataout,
   input  logic                           lifo_val,
   input  logic                           lifo_full,
   output logic [$clog2(LIFO_SIZE+1)-1:0] count
);

   localparam int CNT_W = $clog2(LIFO_SIZE + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;

   logic [1:0] state;
   logic       gnt_id;
   logic       gnt_op;
   logic       err_pending;
   logic       last_grant;
   logic       grant_any;
   logic       grant_id;
   logic       push_ok;
   logic       pop_ok;

   // Under contention the requester not served last wins.
   always_comb begin
      grant_any = r0_req | r1_req;
      grant_id  = 1'b0;
      if (r0_req && r1_req)
         grant_id = ~last_grant;
      else if (r1_req)
         grant_id = 1'b1;
   end

   assign push_ok    = (state == ISSUE) && !gnt_op && !lifo_full;
   assign pop_ok     = (state == ISSUE) &&  gnt_op &&  lifo_val;
   assign lifo_write = push_ok;
   assign lifo_read  = pop_ok;

   assign r0_ack = (state == RESP) && !gnt_id;
   assign r1_ack = (state == RESP) &&  gnt_id;
   assign r0_err = r0_ack && err_pending;
   assign r1_err = r1_ack && err_pending;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         gnt_id      <= 1'b0;
         gnt_op      <= 1'b0;
         err_pending <= 1'b0;
         last_grant  <= 1'b1;
         lifo_datain <= '0;
         r0_rdata    <= '0;
         r1_rdata    <= '0;
         count       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  gnt_id      <= grant_id;
                  gnt_op      <= grant_id ? r1_op : r0_op;
                  lifo_datain <= grant_id ? r1_wdata : r0_wdata;
                  err_pending <= 1'b0;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               err_pending <= gnt_op ? !lifo_val : lifo_full;
               if (push_ok && count < CNT_W'(LIFO_SIZE))
                  count <= count + 1'b1;
               if (pop_ok && count != '0)
                  count <= count - 1'b1;
               // A pop from an empty stack reports zero data.
               if (gnt_op) begin
                  if (gnt_id)
                     r1_rdata <= lifo_val ? lifo_dataout : '0;
                  else
                     r0_rdata <= lifo_val ? lifo_dataout : '0;
               end
               state <= RESP;
            end
            RESP: begin
               last_grant <= gnt_id;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Randomized scoreboard bench for lifo_arbiter with an attached stack model.
module tb_lifo_arbiter;
   localparam int DW = 10;
   localparam int SZ = 6;
   localparam int CW = $clog2(SZ + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          r0_req = 1'b0, r0_op = 1'b0;
   logic [DW-1:0] r0_wdata = '0;
   logic          r1_req = 1'b0, r1_op = 1'b0;
   logic [DW-1:0] r1_wdata = '0;
   logic          r0_ack, r0_err, r1_ack, r1_err;
   logic [DW-1:0] r0_rdata, r1_rdata;
   logic          lifo_write, lifo_read, lifo_val, lifo_full;
   logic [DW-1:0] lifo_datain, lifo_dataout;
   logic [CW-1:0] count;

   lifo_arbiter #(.DATA_W(DW), .LIFO_SIZE(SZ)) dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_op(r0_op), .r0_wdata(r0_wdata),
      .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_op(r1_op), .r1_wdata(r1_wdata),
      .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
      .lifo_write(lifo_write), .lifo_read(lifo_read), .lifo_datain(lifo_datain),
      .lifo_dataout(lifo_dataout), .lifo_val(lifo_val), .lifo_full(lifo_full),
      .count(count)
   );

   always #5 clk = ~clk;

   // Attached stack: reacts to the DUT strobes like a real LIFO instance.
   logic [DW-1:0] env_mem [SZ];
   int            env_sp = 0;
   always @(posedge clk) begin
      if (reset) env_sp <= 0;
      else if (lifo_write && env_sp < SZ) begin
         env_mem[env_sp] <= lifo_datain;
         env_sp <= env_sp + 1;
      end else if (lifo_read && env_sp > 0) env_sp <= env_sp - 1;
   end
   assign lifo_val     = env_sp > 0;
   assign lifo_full    = env_sp == SZ;
   assign lifo_dataout = env_sp > 0 ? env_mem[env_sp-1] : '0;

   // Reference model: plain stack plus per-requester rdata and grant history.
   typedef struct packed {
      logic          id;
      logic          err;
      logic [DW-1:0] rd;
      logic [DW-1:0] other_rd;
      logic [CW-1:0] cnt;
   } exp_t;
   exp_t          sb[$];
   logic [DW-1:0] mdl[$];
   logic [DW-1:0] mdl_rdata [2];
   bit            mdl_last = 1'b1;
   int            checks = 0, passes = 0;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   function automatic exp_t predict(input bit id, input bit op, input logic [DW-1:0] wd);
      exp_t e;
      e.id = id;
      if (!op) begin
         e.err = mdl.size() >= SZ;
         if (!e.err) mdl.push_back(wd);
      end else begin
         e.err = mdl.size() == 0;
         mdl_rdata[id] = e.err ? '0 : mdl.pop_back();
      end
      e.rd       = mdl_rdata[id];
      e.other_rd = mdl_rdata[!id];
      e.cnt      = CW'(mdl.size());
      mdl_last   = id;
      return e;
   endfunction

   function automatic void model_reset();
      mdl.delete();
      sb.delete();
      mdl_last     = 1'b1;
      mdl_rdata[0] = '0;
      mdl_rdata[1] = '0;
   endfunction

   // Monitor: every ack is matched against the next scoreboard entry.
   bit prev_strobe = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         if (r0_ack || r1_ack) begin
            if (sb.size() == 0) check("unexpected_ack", 1, 0);
            else begin
               exp_t e;
               e = sb.pop_front();
               check("ack_id", {r1_ack, r0_ack}, e.id ? 2 : 1);
               check("err", e.id ? r1_err : r0_err, e.err);
               check("rdata", e.id ? r1_rdata : r0_rdata, e.rd);
               check("other_rdata", e.id ? r0_rdata : r1_rdata, e.other_rd);
               check("count", count, e.cnt);
            end
         end
         if (lifo_write || lifo_read) begin
            check("strobe_excl", lifo_write & lifo_read, 0);
            check("strobe_pulse", prev_strobe, 0);
         end
         prev_strobe <= lifo_write | lifo_read;
      end else prev_strobe <= 1'b0;
   end

   task automatic set_req(input bit id, input bit req, input bit op, input logic [DW-1:0] wd);
      if (id) begin r1_req = req; r1_op = op; r1_wdata = wd; end
      else    begin r0_req = req; r0_op = op; r0_wdata = wd; end
   endtask

   // Single operation from an idle DUT with latency/strobe checks.
   task automatic do_op(input bit id, input bit op, input logic [DW-1:0] wd);
      exp_t e;
      @(negedge clk);
      e = predict(id, op, wd);
      sb.push_back(e);
      set_req(id, 1'b1, op, wd);
      @(negedge clk);
      check("write_strobe", lifo_write, (!op && !e.err) ? 1 : 0);
      check("read_strobe", lifo_read, (op && !e.err) ? 1 : 0);
      if (!op && !e.err) check("datain", lifo_datain, wd);
      @(negedge clk);
      check("ack_latency", id ? r1_ack : r0_ack, 1);
      set_req(id, 1'b0, 1'b0, '0);
   endtask

   // Both requesters held high for n operations each: grants must alternate.
   task automatic do_both(input int n);
      bit            opv [2][4];
      logic [DW-1:0] wdv [2][4];
      int            idx [2];
      bit            w;
      int            cyc = 0, last_ack = -1;
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < 4; k++) begin
            opv[r][k] = 1'($urandom_range(0, 1));
            wdv[r][k] = DW'($urandom_range(0, 1023));
         end
      w = !mdl_last;
      for (int k = 0; k < 2 * n; k++) begin
         bit id;
         id = (k % 2 == 0) ? w : !w;
         sb.push_back(predict(id, opv[id][k/2], wdv[id][k/2]));
      end
      idx[0] = 0; idx[1] = 0;
      @(negedge clk);
      set_req(1'b0, 1'b1, opv[0][0], wdv[0][0]);
      set_req(1'b1, 1'b1, opv[1][0], wdv[1][0]);
      while ((idx[0] < n || idx[1] < n) && cyc < 20 * n) begin
         @(negedge clk);
         cyc++;
         if (r0_ack || r1_ack) begin
            if (last_ack >= 0) check("ack_spacing", cyc - last_ack, 3);
            last_ack = cyc;
         end
         for (int r = 0; r < 2; r++)
            if (r == 0 ? r0_ack : r1_ack) begin
               idx[r]++;
               if (idx[r] < n) set_req(r[0], 1'b1, opv[r][idx[r]], wdv[r][idx[r]]);
               else            set_req(r[0], 1'b0, 1'b0, '0);
            end
      end
      if (idx[0] < n || idx[1] < n) begin
         check("both_timeout", 0, 1);
         set_req(1'b0, 1'b0, 1'b0, '0);
         set_req(1'b1, 1'b0, 1'b0, '0);
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_ack", {r1_ack, r0_ack, r1_err, r0_err}, 0);
      check("rst_strobe", {lifo_write, lifo_read}, 0);
      check("rst_count", count, 0);
      check("rst_rdata", {r1_rdata, r0_rdata}, 0);
      check("rst_datain", lifo_datain, 0);
      reset = 1'b0;

      do_op(1'b0, 1'b0, 10'h155);
      do_op(1'b1, 1'b1, '0);
      do_op(1'b0, 1'b1, '0);
      for (int i = 1; i <= 6; i++) do_op(i[0], 1'b0, DW'(i));
      do_op(1'b0, 1'b0, 10'h3FF);
      for (int i = 0; i < 6; i++) do_op(i[0], 1'b1, '0);
      do_both(2);

      // Reset while a push sits in ISSUE.
      @(negedge clk);
      set_req(1'b0, 1'b1, 1'b0, 10'h2AA);
      @(negedge clk);
      reset = 1'b1;
      set_req(1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      check("rst_mid_write", lifo_write, 0);
      check("rst_mid_count", count, 0);
      check("rst_mid_ack", {r1_ack, r0_ack}, 0);
      model_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_ack", {r1_ack, r0_ack}, 0);
      do_both(1);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0) do_both(int'($urandom_range(1, 3)));
         else do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    DW'($urandom_range(0, 1023)));
      end

      repeat (4) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
